bit_narrower16: RTL and testbench
=================================

// Module: bit_narrower16
// PURPOSE
//  Inverse of the 16->24 pad extender: returns 24-bit datapath words to 16-bit sample width
//  for the MSDAP output path. Applies an optional arithmetic right shift, then saturates to the
//  16-bit range. Buffers words in a 2-stage valid/ready pipeline between the accumulator and the
//  output serializer, and counts saturation events.
// PARAMETERS
//  FRAC_SHIFT  0   arithmetic right shift applied before saturation (0..8)
//  CNT_W       16  width of saturation event counter
// PORTS
//  Sclk        in   1      system clock; all state changes on rising edge
//  Reset       in   1      synchronous, active-high reset
//  inData      in   24     word to narrow
//  inSigned    in   1      1: signed range [-32768,32767]; 0: unsigned range [0,65535]
//  inValid     in   1      inData/inSigned valid this cycle
//  inReady     out  1      block accepts a word when inValid&&inReady
//  returnData  out  16     narrowed word
//  satFlag     out  1      returnData was clipped (qualified by outValid)
//  outValid    out  1      returnData valid
//  outReady    in   1      consumer takes a word when outValid&&outReady
//  satCount    out  CNT_W  number of clipped words delivered; holds at all-ones
//  satClear    in   1      zeroes satCount next cycle
// BEHAVIOUR
//  - Reset: outValid=0, returnData=0, satFlag=0, satCount=0, both stage valids=0; inReady=1
//    the cycle after Reset deasserts. A word in flight during Reset is discarded.
//  - Stage 1 (accept): on inValid&&inReady, register s1 = {inData[23]&inSigned, inData} >>> FRAC_SHIFT
//    (25-bit arithmetic shift; sign bit is 0 in unsigned mode), plus inSigned.
//  - Stage 2 (saturate/output): signed mode: if s1 in [-32768,32767], returnData=s1[15:0], satFlag=0;
//    else returnData = s1 negative ? 16'h8000 : 16'h7FFF, satFlag=1.
//    Unsigned mode: if s1[24:16]==0, pass s1[15:0]; else 16'hFFFF, satFlag=1.
//  - Latency: 2 cycles from accept to outValid when outReady held high; throughput 1 word/cycle.
//  - Handshake: stage 2 advances when !outValid || outReady; stage 1 advances when stage 2 advances
//    or stage 1 empty. inReady = !s1Valid || stage-2-advance (combinational from outReady).
//  - returnData/satFlag stay stable while outValid && !outReady. outValid never drops without a
//    transfer.
//  - Full: both stages valid and outReady=0 -> inReady=0; no word lost or duplicated.
//  - Empty: outValid=0; returnData holds last delivered value.
//  - satCount increments on each transfer (outValid&&outReady) with satFlag=1; saturates at
//    all-ones, no wrap. satClear wins over a simultaneous increment (result 0).
//  - Boundaries: 24'h007FFF signed -> 7FFF no sat; 24'h008000 signed -> 7FFF sat;
//    24'hFF8000 signed -> 8000 no sat; 24'hFF7FFF signed -> 8000 sat.
// CONFIGURATION
//  NARROW_ROUND_EN defined: stage 1 adds 1<<(FRAC_SHIFT-1) to the 25-bit value before the shift
//    (round half up); ignored when FRAC_SHIFT=0. Overflow of the add is prevented by the 25-bit
//    intermediate; a rounded result that leaves range is saturated normally.
//  NARROW_ROUND_EN undefined: plain truncating shift, no adder in stage 1.
// TESTING
//  1. Reset mid-stream with 2 words in flight -> outValid=0 next cycle, satCount=0, none emitted later.
//  2. Signed stream 007FFF,008000,FF8000,FF7FFF, outReady=1 -> 7FFF/0,7FFF/1,8000/0,8000/1 at
//     cycles +2..+5; satCount=2.
//  3. Unsigned 00FFFF,010000,FFFFFF -> FFFF/0,FFFF/1,FFFF/1; satCount=2.
//  4. outReady=0 for 5 cycles, inValid=1 -> inReady low after 2 accepts, returnData stable;
//     on release all words emerge in order, none dropped.
//  5. FRAC_SHIFT=4, input 000018: without NARROW_ROUND_EN -> 0001; with it -> 0002.
//  6. satCount preloaded to FFFF by forced saturations -> holds FFFF; satClear with a
//     simultaneous sat transfer -> 0000.

Source files
------------

// File: rtl/bit_narrower16.sv
// bit_narrower16: narrows 24-bit datapath words to 16 bits with optional shift, saturation and a 2-stage valid/ready pipeline.
// Optional rounding before the shift is enabled by defining NARROW_ROUND_EN.
`timescale 1ns/1ps
module bit_narrower16 #(
    parameter int FRAC_SHIFT = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Sclk,
    input  logic             Reset,
    input  logic [23:0]      inData,
    input  logic             inSigned,
    input  logic             inValid,
    output logic             inReady,
    output logic [15:0]      returnData,
    output logic             satFlag,
    output logic             outValid,
    input  logic             outReady,
    output logic [CNT_W-1:0] satCount,
    input  logic             satClear
);
    logic             s1_valid_q, s1_valid_d;
    logic [24:0]      s1_data_q, s1_data_d;
    logic             s1_signed_q, s1_signed_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      ret_q, ret_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [25:0]      ext, sum;
    logic [24:0]      shifted;
    logic             adv2, accept, in_range;
    // one extra bit above the 25-bit word keeps an unsigned rounding carry from looking negative
    assign ext = {{2{inData[23] & inSigned}}, inData};
`ifdef NARROW_ROUND_EN
    localparam int          RS  = FRAC_SHIFT > 0 ? FRAC_SHIFT - 1 : 0;
    localparam logic [25:0] RND = FRAC_SHIFT > 0 ? 26'(1) << RS : 26'd0;
    assign sum = ext + RND;
`else
    assign sum = ext;
`endif
    // next-state for both pipeline stages and the saturation counter
    always_comb begin
        shifted     = 25'($signed(sum) >>> FRAC_SHIFT);
        adv2        = !out_valid_q || outReady;
        accept      = inValid && inReady;
        in_range    = s1_signed_q ? (&s1_data_q[24:15] || ~|s1_data_q[24:15]) : ~|s1_data_q[24:16];
        s1_valid_d  = accept ? 1'b1 : (adv2 ? 1'b0 : s1_valid_q);
        s1_data_d   = accept ? shifted : s1_data_q;
        s1_signed_d = accept ? inSigned : s1_signed_q;
        out_valid_d = adv2 ? s1_valid_q : out_valid_q;
        ret_d       = ret_q;
        sat_d       = sat_q;
        if (adv2 && s1_valid_q) begin
            ret_d = in_range ? s1_data_q[15:0] : (s1_signed_q ? (s1_data_q[24] ? 16'h8000 : 16'h7FFF) : 16'hFFFF);
            sat_d = !in_range;
        end
        cnt_d = satClear ? '0 : (out_valid_q && outReady && sat_q && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    // state registers; reset discards any word in flight
    always_ff @(posedge Sclk) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_signed_q <= 1'b0;
            out_valid_q <= 1'b0;
            ret_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_signed_q <= s1_signed_d;
            out_valid_q <= out_valid_d;
            ret_q       <= ret_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
        end
    end
    assign inReady    = !s1_valid_q || adv2;
    assign returnData = ret_q;
    assign satFlag    = sat_q;
    assign outValid   = out_valid_q;
    assign satCount   = cnt_q;
endmodule

// File: tb/tb_bit_narrower16.sv
// tb_bit_narrower16: directed self-checking bench for bit_narrower16.
`timescale 1ns/1ps
module tb_bit_narrower16;
    logic        clk = 0, rst = 1, in_signed = 0, in_valid = 0, out_ready = 1, sat_clear = 0;
    logic [23:0] in_data = '0;
    logic        iready, osat, ovalid, r4_ready, r4_sat, r4_valid;
    logic [15:0] odata, ocnt, r4_data, r4_cnt;
    int n_cmp = 0, n_bad = 0;
`ifdef NARROW_ROUND_EN
    localparam logic [15:0] R4_EXP = 16'h0002;
`else
    localparam logic [15:0] R4_EXP = 16'h0001;
`endif
    bit_narrower16 #(.FRAC_SHIFT(0), .CNT_W(16)) dut (
        .Sclk(clk), .Reset(rst), .inData(in_data), .inSigned(in_signed), .inValid(in_valid),
        .inReady(iready), .returnData(odata), .satFlag(osat), .outValid(ovalid),
        .outReady(out_ready), .satCount(ocnt), .satClear(sat_clear));
    bit_narrower16 #(.FRAC_SHIFT(4), .CNT_W(16)) dut4 (
        .Sclk(clk), .Reset(rst), .inData(in_data), .inSigned(in_signed), .inValid(in_valid),
        .inReady(r4_ready), .returnData(r4_data), .satFlag(r4_sat), .outValid(r4_valid),
        .outReady(out_ready), .satCount(r4_cnt), .satClear(sat_clear));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic stream(input string tag, input logic sgn, input logic [23:0] w[4],
                          input logic [15:0] e[4], input logic es[4], input int n);
        for (int k = 0; k <= n; k++) begin
            in_valid  = k < n;
            in_data   = k < n ? w[k] : 24'h0;
            in_signed = sgn;
            tick;
            if (k >= 1) begin
                chk({tag, "_valid"}, 32'(ovalid), 32'(1));
                chk({tag, "_data"}, 32'(odata), 32'(e[k-1]));
                chk({tag, "_sat"}, 32'(osat), 32'(es[k-1]));
            end
        end
        in_valid = 0;
        tick;
        chk({tag, "_drain"}, 32'(ovalid), 32'(0));
    endtask
    initial begin
        logic [23:0] w[4];
        logic [15:0] e[4];
        logic        es[4];
        int ai, oi;
        tick;
        tick;
        rst = 0;
        chk("rst_valid", 32'(ovalid), 32'(0));
        chk("rst_data", 32'(odata), 32'(0));
        chk("rst_sat", 32'(osat), 32'(0));
        chk("rst_cnt", 32'(ocnt), 32'(0));
        chk("rst_ready", 32'(iready), 32'(1));
        // reset with two saturating words in flight
        out_ready = 0; in_valid = 1; in_signed = 1; in_data = 24'h008000;
        tick;
        in_data = 24'hFF7FFF;
        tick;
        chk("mid_valid", 32'(ovalid), 32'(1));
        in_valid = 0; rst = 1;
        tick;
        rst = 0; out_ready = 1;
        chk("midrst_valid", 32'(ovalid), 32'(0));
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("midrst_none", 32'(ovalid), 32'(0));
        end
        chk("midrst_cnt", 32'(ocnt), 32'(0));
        // signed boundaries
        w  = '{24'h007FFF, 24'h008000, 24'hFF8000, 24'hFF7FFF};
        e  = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        es = '{1'b0, 1'b1, 1'b0, 1'b1};
        stream("sgn", 1'b1, w, e, es, 4);
        chk("sgn_cnt", 32'(ocnt), 32'(2));
        sat_clear = 1;
        tick;
        sat_clear = 0;
        chk("clr_cnt", 32'(ocnt), 32'(0));
        // unsigned range
        w  = '{24'h00FFFF, 24'h010000, 24'hFFFFFF, 24'h0};
        e  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0};
        es = '{1'b0, 1'b1, 1'b1, 1'b0};
        stream("uns", 1'b0, w, e, es, 3);
        chk("uns_cnt", 32'(ocnt), 32'(2));
        // backpressure: 5 stalled cycles, then drain in order
        ai = 0; oi = 0;
        for (int c = 0; c < 30 && oi < 5; c++) begin
            out_ready = c >= 5;
            in_valid  = ai < 5;
            in_data   = 24'(ai + 1);
            in_signed = 1;
            #1;
            if (c >= 2 && c < 5) begin
                chk("full_ready", 32'(iready), 32'(0));
                chk("stall_data", 32'(odata), 32'(1));
                chk("stall_valid", 32'(ovalid), 32'(1));
            end
            if (ovalid && out_ready) begin
                chk("order", 32'(odata), 32'(oi + 1));
                oi++;
            end
            if (in_valid && iready) ai++;
            tick;
        end
        in_valid = 0; out_ready = 1;
        chk("bp_out", 32'(oi), 32'(5));
        chk("bp_in", 32'(ai), 32'(5));
        tick;
        chk("bp_drain", 32'(ovalid), 32'(0));
        // fractional shift of 4 on the second instance
        in_valid = 1; in_signed = 1; in_data = 24'h000018;
        tick;
        in_valid = 0;
        tick;
        chk("sh4_valid", 32'(r4_valid), 32'(1));
        chk("sh4_data", 32'(r4_data), 32'(R4_EXP));
        chk("sh0_data", 32'(odata), 32'(16'h0018));
        tick;
        // counter saturation, then clear against a simultaneous saturating transfer
        in_valid = 1; in_signed = 1; in_data = 24'h008000;
        for (int i = 0; i < 65540; i++) tick;
        chk("cnt_hold", 32'(ocnt), 32'(16'hFFFF));
        tick;
        chk("cnt_hold2", 32'(ocnt), 32'(16'hFFFF));
        chk("cnt_xfer_sat", 32'(ovalid & osat), 32'(1));
        sat_clear = 1;
        tick;
        sat_clear = 0;
        chk("cnt_clear", 32'(ocnt), 32'(0));
        tick;
        chk("cnt_after", 32'(ocnt), 32'(1));
        in_valid = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
